// File: rtl/mc_bus_arbiter.sv
// Round-robin multicast bus arbiter: grants one requester at a time for bounded bursts
// and registers each accepted beat onto the shared bus. Optional counters: MC_ARB_STATS_EN.
module mc_bus_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int DATA_W    = 16,
   parameter int TAG_W     = 4,
   parameter int MAX_BURST = 4,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_val,
   input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        bus_valid,
   output logic [DATA_W-1:0]           bus_val,
   output logic [TAG_W-1:0]            bus_tag,
   input  logic                        bus_ready,
   output logic [ID_W-1:0]             grant_id,
   output logic                        busy
`ifdef MC_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]       stat_beats,
   output logic [15:0]                 stat_stall
`endif
);

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [ID_W-1:0]  PTR_INIT  = ID_W'(NUM_REQ - 1);

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     grant_id_reg, grant_id_next;
   logic [ID_W-1:0]     last_ptr_reg, last_ptr_next;
   logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
   logic                bus_valid_reg, bus_valid_next;
   logic [DATA_W-1:0]   bus_val_reg, bus_val_next;
   logic [TAG_W-1:0]    bus_tag_reg, bus_tag_next;

   logic [DATA_W-1:0]   val_arr [NUM_REQ];
   logic [TAG_W-1:0]    tag_arr [NUM_REQ];
   logic [ID_W-1:0]     winner;
   logic                out_free;
   logic                gnt_valid;
   logic                accept;
   int                  sel_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign val_arr[gi]   = req_val[gi*DATA_W +: DATA_W];
         assign tag_arr[gi]   = req_tag[gi*TAG_W +: TAG_W];
         assign req_ready[gi] = (state_reg == BURST) && (grant_id_reg == ID_W'(gi)) && out_free;
      end
   endgenerate

   // The output register can take a new beat when empty or draining this cycle.
   assign out_free  = !bus_valid_reg || bus_ready;
   assign gnt_valid = req_valid[grant_id_reg];
   assign accept    = (state_reg == BURST) && gnt_valid && out_free;

   // Search starts just after the previous owner so every requester gets its turn.
   always_comb begin
      winner  = '0;
      sel_idx = 0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         sel_idx = (int'(last_ptr_reg) + off) % NUM_REQ;
         if (req_valid[sel_idx]) begin
            winner = ID_W'(sel_idx);
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_id_next = grant_id_reg;
      last_ptr_next = last_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      unique case (state_reg)
         IDLE: begin
            if (|req_valid) begin
               grant_id_next = winner;
               beat_cnt_next = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            if (accept) begin
               beat_cnt_next = beat_cnt_reg + 1'b1;
               if (beat_cnt_reg == LAST_BEAT) begin
                  state_next    = IDLE;
                  last_ptr_next = grant_id_reg;
               end
            end else if (out_free && !gnt_valid) begin
               state_next    = IDLE;
               last_ptr_next = grant_id_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus_valid_next = bus_valid_reg;
      bus_val_next   = bus_val_reg;
      bus_tag_next   = bus_tag_reg;
      if (accept) begin
         bus_valid_next = 1'b1;
         bus_val_next   = val_arr[grant_id_reg];
         bus_tag_next   = tag_arr[grant_id_reg];
      end else if (bus_ready) begin
         bus_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         grant_id_reg  <= '0;
         last_ptr_reg  <= PTR_INIT;
         beat_cnt_reg  <= '0;
         bus_valid_reg <= 1'b0;
         bus_val_reg   <= '0;
         bus_tag_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         grant_id_reg  <= grant_id_next;
         last_ptr_reg  <= last_ptr_next;
         beat_cnt_reg  <= beat_cnt_next;
         bus_valid_reg <= bus_valid_next;
         bus_val_reg   <= bus_val_next;
         bus_tag_reg   <= bus_tag_next;
      end
   end

   assign bus_valid = bus_valid_reg;
   assign bus_val   = bus_val_reg;
   assign bus_tag   = bus_tag_reg;
   assign grant_id  = grant_id_reg;
   assign busy      = (state_reg == BURST);

`ifdef MC_ARB_STATS_EN
   logic [15:0] stat_stall_reg;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
         logic [15:0] beats_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               beats_reg <= '0;
            end else if (accept && (grant_id_reg == ID_W'(gi)) && (beats_reg != 16'hFFFF)) begin
               beats_reg <= beats_reg + 16'd1;
            end
         end
         assign stat_beats[gi*16 +: 16] = beats_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_stall_reg <= '0;
      end else if (bus_valid_reg && !bus_ready && (stat_stall_reg != 16'hFFFF)) begin
         stat_stall_reg <= stat_stall_reg + 16'd1;
      end
   end

   assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_mc_bus_arbiter.sv
// Directed bench for mc_bus_arbiter: vector table for single-owner, stall and early-drop
// sequences, plus hand-written rotation, async-reset and (with MC_ARB_STATS_EN) counter checks.
module tb_mc_bus_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    req_valid = '0;
   logic [47:0]   req_val = '0;
   logic [11:0]   req_tag = '0;
   logic [2:0]    req_ready;
   logic          bus_valid;
   logic [15:0]   bus_val;
   logic [3:0]    bus_tag;
   logic          bus_ready = 1'b1;
   logic [1:0]    grant_id;
   logic          busy;
`ifdef MC_ARB_STATS_EN
   logic [47:0]   stat_beats;
   logic [15:0]   stat_stall;
`endif

   int checks = 0;
   int errors = 0;

   mc_bus_arbiter #(
      .NUM_REQ(3), .DATA_W(16), .TAG_W(4), .MAX_BURST(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_val(req_val), .req_tag(req_tag), .req_ready(req_ready),
      .bus_valid(bus_valid), .bus_val(bus_val), .bus_tag(bus_tag), .bus_ready(bus_ready),
      .grant_id(grant_id), .busy(busy)
`ifdef MC_ARB_STATS_EN
      , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      logic [2:0]  rv;
      logic [15:0] v0, v1, v2;
      logic [3:0]  t0, t1, t2;
      logic        brdy;
      logic [2:0]  e_rr;
      logic        e_bv;
      logic [15:0] e_val;
      logic [3:0]  e_tag;
      logic [1:0]  e_gid;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   function automatic void add(bit r, logic [2:0] rv, logic [15:0] v0, logic [3:0] t0,
                               logic [15:0] v1, logic [3:0] t1, logic [15:0] v2, logic [3:0] t2,
                               logic brdy, logic [2:0] e_rr, logic e_bv, logic [15:0] e_val,
                               logic [3:0] e_tag, logic [1:0] e_gid, logic e_busy);
      vec_t v;
      v.do_rst = r; v.rv = rv; v.v0 = v0; v.t0 = t0; v.v1 = v1; v.t1 = t1;
      v.v2 = v2; v.t2 = t2; v.brdy = brdy; v.e_rr = e_rr; v.e_bv = e_bv;
      v.e_val = e_val; v.e_tag = e_tag; v.e_gid = e_gid; v.e_busy = e_busy;
      vq.push_back(v);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic [2:0] rv, logic [15:0] v0, logic [3:0] t0, logic [15:0] v1,
                        logic [3:0] t1, logic [15:0] v2, logic [3:0] t2, logic brdy);
      req_valid = rv;
      req_val   = {v2, v1, v0};
      req_tag   = {t2, t1, t0};
      bus_ready = brdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(3'b000, 16'h0, 4'h0, 16'h0, 4'h0, 16'h0, 4'h0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt [3];
      int p, ph, owner;
      int beats;

      // single owner, 3 beats with tag 5
      add(1, 3'b001, 16'h0011, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b000, 0, 16'h0000, 4'h0, 2'd0, 1);
      add(0, 3'b001, 16'h0011, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h0011, 4'h5, 2'd0, 1);
      add(0, 3'b001, 16'h0022, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h0022, 4'h5, 2'd0, 1);
      add(0, 3'b001, 16'h0033, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h0033, 4'h5, 2'd0, 1);
      add(0, 3'b000, 16'h0033, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 0, 16'h0033, 4'h5, 2'd0, 0);
      add(0, 3'b000, 16'h0033, 4'h5, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b000, 0, 16'h0033, 4'h5, 2'd0, 0);
      // 5-cycle stall after the first beat
      add(1, 3'b001, 16'h00A0, 4'h1, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b000, 0, 16'h0000, 4'h0, 2'd0, 1);
      add(0, 3'b001, 16'h00A0, 4'h1, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h00A0, 4'h1, 2'd0, 1);
      for (int i = 0; i < 5; i++)
         add(0, 3'b001, 16'h00A1, 4'h2, 16'h0, 4'h0, 16'h0, 4'h0, 0, 3'b000, 1, 16'h00A0, 4'h1, 2'd0, 1);
      add(0, 3'b001, 16'h00A1, 4'h2, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h00A1, 4'h2, 2'd0, 1);
      add(0, 3'b001, 16'h00A2, 4'h3, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h00A2, 4'h3, 2'd0, 1);
      add(0, 3'b001, 16'h00A3, 4'h4, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b001, 1, 16'h00A3, 4'h4, 2'd0, 0);
      add(0, 3'b000, 16'h00A3, 4'h4, 16'h0, 4'h0, 16'h0, 4'h0, 1, 3'b000, 0, 16'h00A3, 4'h4, 2'd0, 0);
      // req 1 drops after 2 beats; req 2 must win over req 0 next
      add(1, 3'b110, 16'h0BAD, 4'h0, 16'h1001, 4'h1, 16'h2001, 4'h2, 1, 3'b000, 0, 16'h0000, 4'h0, 2'd1, 1);
      add(0, 3'b110, 16'h0BAD, 4'h0, 16'h1001, 4'h1, 16'h2001, 4'h2, 1, 3'b010, 1, 16'h1001, 4'h1, 2'd1, 1);
      add(0, 3'b110, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b010, 1, 16'h1002, 4'h1, 2'd1, 1);
      add(0, 3'b100, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b010, 0, 16'h1002, 4'h1, 2'd1, 0);
      add(0, 3'b101, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b000, 0, 16'h1002, 4'h1, 2'd2, 1);
      add(0, 3'b101, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b100, 1, 16'h2001, 4'h2, 2'd2, 1);
      add(0, 3'b001, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b100, 0, 16'h2001, 4'h2, 2'd2, 0);
      add(0, 3'b000, 16'h0BAD, 4'h0, 16'h1002, 4'h1, 16'h2001, 4'h2, 1, 3'b000, 0, 16'h2001, 4'h2, 2'd2, 0);

      // reset values
      do_reset();
      #1;
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_bus_val",   32'(bus_val),   32'd0);
      chk("rst_bus_tag",   32'(bus_tag),   32'd0);
      chk("rst_grant_id",  32'(grant_id),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      foreach (vq[i]) begin
         if (vq[i].do_rst) do_reset();
         @(negedge clk);
         drive(vq[i].rv, vq[i].v0, vq[i].t0, vq[i].v1, vq[i].t1, vq[i].v2, vq[i].t2, vq[i].brdy);
         #1;
         chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vq[i].e_rr));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_bus_valid", i), 32'(bus_valid), 32'(vq[i].e_bv));
         chk($sformatf("vec%0d_bus_val", i),   32'(bus_val),   32'(vq[i].e_val));
         chk($sformatf("vec%0d_bus_tag", i),   32'(bus_tag),   32'(vq[i].e_tag));
         chk($sformatf("vec%0d_grant_id", i),  32'(grant_id),  32'(vq[i].e_gid));
         chk($sformatf("vec%0d_busy", i),      32'(busy),      32'(vq[i].e_busy));
         $display("vec %0d: rv=%b rr=%b bv=%b val=%h tag=%h gid=%0d busy=%b",
                  i, vq[i].rv, req_ready, bus_valid, bus_val, bus_tag, grant_id, busy);
      end

      // all three requesters always valid: grant order 0,1,2,0, 4 beats + 1 idle each
      do_reset();
      cnt = '{0, 0, 0};
      for (int c = 0; c < 20; c++) begin
         p = c / 5; ph = c % 5; owner = p % 3;
         @(negedge clk);
         drive(3'b111, 16'(cnt[0]), 4'h1, 16'(16'h0100 + cnt[1]), 4'h2,
               16'(16'h0200 + cnt[2]), 4'h3, 1'b1);
         #1;
         chk($sformatf("rr_req_ready_c%0d", c), 32'(req_ready), (ph == 0) ? 32'd0 : (32'd1 << owner));
         @(posedge clk);
         #1;
         chk($sformatf("rr_grant_c%0d", c), 32'(grant_id), 32'(owner));
         chk($sformatf("rr_bus_valid_c%0d", c), 32'(bus_valid), (ph == 0) ? 32'd0 : 32'd1);
         chk($sformatf("rr_busy_c%0d", c), 32'(busy), (ph == 4) ? 32'd0 : 32'd1);
         if (ph != 0) begin
            chk($sformatf("rr_bus_val_c%0d", c), 32'(bus_val), 32'(owner * 256 + cnt[owner]));
            chk($sformatf("rr_bus_tag_c%0d", c), 32'(bus_tag), 32'(owner + 1));
            cnt[owner]++;
         end
         $display("rr cycle %0d: gid=%0d bv=%b val=%h tag=%h busy=%b",
                  c, grant_id, bus_valid, bus_val, bus_tag, busy);
      end

      // asynchronous reset mid-burst while requester 1 owns the bus
      do_reset();
      @(negedge clk);
      drive(3'b010, 16'h0A0A, 4'h6, 16'h5555, 4'h3, 16'h0, 4'h0, 1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("arst_pre_bus_valid", 32'(bus_valid), 32'd1);
      chk("arst_pre_grant", 32'(grant_id), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_bus_valid", 32'(bus_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_grant", 32'(grant_id), 32'd0);
      chk("arst_bus_val", 32'(bus_val), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b011, 16'h0A0A, 4'h6, 16'h5555, 4'h3, 16'h0, 4'h0, 1'b1);
      @(posedge clk);
      #1;
      chk("arst_regrant", 32'(grant_id), 32'd0);
      chk("arst_regrant_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      chk("arst_first_val", 32'(bus_val), 32'h0A0A);
      chk("arst_first_tag", 32'(bus_tag), 32'h6);
      $display("async reset: regrant gid=%0d val=%h tag=%h", grant_id, bus_val, bus_tag);

`ifdef MC_ARB_STATS_EN
      // 10 beats from requester 2 with a 3-cycle stall
      do_reset();
      beats = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         drive((beats < 10) ? 3'b100 : 3'b000, 16'h0, 4'h0, 16'h0, 4'h0,
               16'(16'h0C00 + beats), 4'hC, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
         #1;
         if (req_valid[2] && req_ready[2]) beats++;
      end
      chk("stat_beats2", 32'(stat_beats[47:32]), 32'd10);
      chk("stat_beats1", 32'(stat_beats[31:16]), 32'd0);
      chk("stat_beats0", 32'(stat_beats[15:0]), 32'd0);
      chk("stat_stall", 32'(stat_stall), 32'd3);
      $display("stats: beats2=%0d stall=%0d", stat_beats[47:32], stat_stall);
`else
      beats = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
